// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle unsigned shift-add multiplier sharing the divider's Load/Done handshake.
// One multiplier bit is retired per RUN cycle; the full product is published in FINISH.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] P_hi,
  output logic [WIDTH-1:0] P_lo,
  output logic             Done,
  output logic             Busy,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_hi_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH:0]   sum_s;

  // Partial-product add; the extra bit keeps the carry for the right shift.
  always_comb begin
    sum_s = {1'b0, acc_hi_r};
    if (mplier_r[0]) begin
      sum_s = {1'b0, acc_hi_r} + {1'b0, mcand_r};
    end else begin
      sum_s = {1'b0, acc_hi_r};
    end
  end

  assign Busy = (state_r == RUN) || (state_r == FINISH);

  // Control FSM, shift-add datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r  <= IDLE;
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_hi_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      P_hi     <= {WIDTH{1'b0}};
      P_lo     <= {WIDTH{1'b0}};
      Done     <= 1'b0;
      Ovf      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (Load) begin
            mcand_r  <= A;
            mplier_r <= B;
            acc_hi_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            Done     <= 1'b0;
            Ovf      <= 1'b0;
            state_r  <= RUN;
          end else begin
            state_r  <= IDLE;
          end
        end
        RUN: begin
          // Carry enters acc_hi MSB; the consumed multiplier bit falls off the bottom.
          {acc_hi_r, mplier_r} <= {sum_s, mplier_r[WIDTH-1:1]};
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= FINISH;
          end else begin
            state_r <= RUN;
          end
        end
        FINISH: begin
          P_hi    <= acc_hi_r;
          P_lo    <= mplier_r;
          Ovf     <= |acc_hi_r;
          Done    <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier: a cycle-level behavioural model
// queues expected products on accept; a monitor pops them when Done rises.
module tb_seq_shift_add_multiplier;

  localparam int W   = 16;
  localparam int LAT = W + 2;   // edges from the accepting edge to the edge after Done

  logic         clk;
  logic         Reset;
  logic         Load;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] P_hi;
  logic [W-1:0] P_lo;
  logic         Done;
  logic         Busy;
  logic         Ovf;

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk  (clk),
    .Reset(Reset),
    .Load (Load),
    .A    (A),
    .B    (B),
    .P_hi (P_hi),
    .P_lo (P_lo),
    .Done (Done),
    .Busy (Busy),
    .Ovf  (Ovf)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int           cyc      = 0;
  int           busy_cnt = 0;
  exp_t         cur      = '{hi: '0, lo: '0, ovf: 1'b0, acc_cyc: 0};
  logic [W-1:0] m_hi     = '0;
  logic [W-1:0] m_lo     = '0;
  logic         m_ovf    = 1'b0;
  logic         m_done   = 1'b0;
  logic         prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t product(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
    exp_t e;
    longint unsigned p;
    p = longint'(a) * longint'(b);
    e.hi = p[2*W-1:W];
    e.lo = p[W-1:0];
    e.ovf = (p[2*W-1:W] != 0);
    e.acc_cyc = c;
    return e;
  endfunction

  // Reference model: IDLE accepts Load; otherwise busy for W+1 edges then publishes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (Reset) begin
      busy_cnt <= 0;
      m_hi     <= '0;
      m_lo     <= '0;
      m_ovf    <= 1'b0;
      m_done   <= 1'b0;
      sb_q.delete();
    end else if (busy_cnt == 0) begin
      if (Load) begin
        cur      <= product(A, B, cyc);
        sb_q.push_back(product(A, B, cyc));
        busy_cnt <= W + 1;
        m_done   <= 1'b0;
        m_ovf    <= 1'b0;
      end
    end else begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        m_hi   <= cur.hi;
        m_lo   <= cur.lo;
        m_ovf  <= cur.ovf;
        m_done <= 1'b1;
      end
    end
  end

  // Monitor: per-cycle output check plus scoreboard pop on Done rising.
  always @(negedge clk) begin
    exp_t e;
    chk("busy", {31'd0, Busy}, {31'd0, (busy_cnt != 0)});
    chk("done", {31'd0, Done}, {31'd0, m_done});
    chk("p_hi", {16'd0, P_hi}, {16'd0, m_hi});
    chk("p_lo", {16'd0, P_lo}, {16'd0, m_lo});
    chk("ovf",  {31'd0, Ovf},  {31'd0, m_ovf});
    if (Done === 1'b1 && prev_done !== 1'b1) begin
      if (sb_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL sb_unexpected_done at cycle %0d: got Done=1 expected no pending result", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_p_hi", {16'd0, P_hi}, {16'd0, e.hi});
        chk("sb_p_lo", {16'd0, P_lo}, {16'd0, e.lo});
        chk("sb_ovf",  {31'd0, Ovf},  {31'd0, e.ovf});
        chk("sb_latency", cyc - e.acc_cyc, LAT);
      end
    end
    prev_done <= Done;
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    Load = 1'b1; A = a; B = b;
    @(negedge clk);
    Load = 1'b0; A = W'($urandom); B = W'($urandom);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    Reset = 1'b1; Load = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("reset_p_hi", {16'd0, P_hi}, 32'd0);
    chk("reset_done", {31'd0, Done}, 32'd0);
    Reset = 1'b0;

    do_op(16'd3, 16'd5);
    chk("t1_p_lo", {16'd0, P_lo}, 32'h0000_000F);
    do_op(16'hFFFF, 16'hFFFF);
    chk("t2_p_hi", {16'd0, P_hi}, 32'h0000_FFFE);
    chk("t2_p_lo", {16'd0, P_lo}, 32'h0000_0001);
    chk("t2_ovf",  {31'd0, Ovf},  32'd1);
    do_op(16'h1234, 16'h0000);
    do_op(16'h0000, 16'hABCD);
    chk("t3_p_lo", {16'd0, P_lo}, 32'd0);

    // Load pulse during RUN must be ignored
    @(negedge clk);
    Load = 1'b1; A = 16'h0100; B = 16'h0100;
    @(negedge clk);
    Load = 1'b0;
    repeat (4) @(negedge clk);
    Load = 1'b1; A = 16'd7; B = 16'd7;
    @(negedge clk);
    Load = 1'b0;
    repeat (20) @(negedge clk);
    chk("t4_p_hi", {16'd0, P_hi}, 32'h0000_0001);
    chk("t4_ovf",  {31'd0, Ovf},  32'd1);

    // Reset mid-RUN aborts the operation
    @(negedge clk);
    Load = 1'b1; A = 16'h00FF; B = 16'h0002;
    @(negedge clk);
    Load = 1'b0;
    repeat (7) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    chk("t5_busy_after_reset", {31'd0, Busy}, 32'd0);
    chk("t5_p_lo_after_reset", {16'd0, P_lo}, 32'd0);
    do_op(16'd2, 16'd2);
    chk("t5_p_lo", {16'd0, P_lo}, 32'h0000_0004);

    // Back-to-back operations with Load held high
    @(negedge clk);
    Load = 1'b1; A = 16'h0010; B = 16'h0010;
    repeat (60) @(negedge clk);
    Load = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_p_lo", {16'd0, P_lo}, 32'h0000_0100);

    // Randomised traffic with stray Loads and occasional resets
    for (int i = 0; i < 1500; i++) begin
      Load  = ($urandom_range(0, 3) == 0);
      A     = W'($urandom);
      B     = W'($urandom);
      Reset = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    Load = 1'b0; Reset = 1'b0;
    repeat (25) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
